// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: drives instruction memory and fills the IF/ID register.
// Optional macro IF_FETCH_COUNT_EN adds a fetch_count output counting delivered instructions.
module if_fetch_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        branch_taken,
  input  logic [31:0] branch_addr,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ack,
  output logic [31:0] instruction,
  output logic [31:0] pc_out,
  output logic        valid,
`ifdef IF_FETCH_COUNT_EN
  output logic [31:0] fetch_count,
`endif
  output logic [1:0]  state_dbg
);

  // Memory handshake: a request (imem_req=1, imem_addr) stays asserted and
  // unchanged until the cycle imem_ack=1; that cycle completes it and
  // imem_rdata is taken only then. A request is never withdrawn early.
  typedef enum logic [1:0] {FETCH = 2'd0, DROP = 2'd1, HOLD = 2'd2} state_t;

  state_t      state, state_n;
  logic [31:0] req_addr, req_addr_n;
  logic [31:0] target, target_n;
  logic [31:0] buf_instr, buf_instr_n;
  logic [31:0] buf_pc, buf_pc_n;
  logic [31:0] instr_n, pc_n;
  logic        valid_n;
  logic [31:0] addr_inc;

  assign addr_inc  = req_addr + 32'd4;
  assign imem_req  = !rst && (state != HOLD);
  assign imem_addr = req_addr;
  assign state_dbg = state;

  always_comb begin
    state_n     = state;
    req_addr_n  = req_addr;
    target_n    = target;
    buf_instr_n = buf_instr;
    buf_pc_n    = buf_pc;
    instr_n     = instruction;
    pc_n        = pc_out;
    valid_n     = valid;
    case (state)
      FETCH: begin
        if (branch_taken) begin
          valid_n = 1'b0;
          if (imem_ack) begin
            req_addr_n = branch_addr;
          end else begin
            target_n = branch_addr;
            state_n  = DROP;
          end
        end else if (imem_ack) begin
          if (freeze) begin
            buf_instr_n = imem_rdata;
            buf_pc_n    = addr_inc;
            state_n     = HOLD;
          end else begin
            instr_n    = imem_rdata;
            pc_n       = addr_inc;
            valid_n    = 1'b1;
            req_addr_n = addr_inc;
          end
        end else if (!freeze) begin
          valid_n = 1'b0;
        end
      end
      DROP: begin
        // Stale request still in flight; a newer redirect replaces the older one.
        valid_n = 1'b0;
        if (branch_taken) target_n = branch_addr;
        if (imem_ack) begin
          req_addr_n = branch_taken ? branch_addr : target;
          state_n    = FETCH;
        end
      end
      HOLD: begin
        if (branch_taken) begin
          valid_n    = 1'b0;
          req_addr_n = branch_addr;
          state_n    = FETCH;
        end else if (!freeze) begin
          instr_n    = buf_instr;
          pc_n       = buf_pc;
          valid_n    = 1'b1;
          req_addr_n = addr_inc;
          state_n    = FETCH;
        end
      end
      default: state_n = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= FETCH;
      req_addr    <= 32'd0;
      target      <= 32'd0;
      buf_instr   <= 32'd0;
      buf_pc      <= 32'd0;
      instruction <= 32'd0;
      pc_out      <= 32'd0;
      valid       <= 1'b0;
    end else begin
      state       <= state_n;
      req_addr    <= req_addr_n;
      target      <= target_n;
      buf_instr   <= buf_instr_n;
      buf_pc      <= buf_pc_n;
      instruction <= instr_n;
      pc_out      <= pc_n;
      valid       <= valid_n;
    end
  end

`ifdef IF_FETCH_COUNT_EN
  logic deliver;
  assign deliver = !branch_taken && !freeze &&
                   ((state == FETCH && imem_ack) || state == HOLD);

  always_ff @(posedge clk) begin
    if (rst) fetch_count <= 32'd0;
    else if (deliver) fetch_count <= fetch_count + 32'd1;
  end
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: directed scenarios then random traffic, checked
// against a transaction-level model of the fetch pipeline.
module tb_if_fetch_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        freeze = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_addr = 32'd0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = 32'd0;
  logic        imem_ack = 1'b0;
  logic [31:0] instruction;
  logic [31:0] pc_out;
  logic        valid;
  logic [1:0]  state_dbg;
`ifdef IF_FETCH_COUNT_EN
  logic [31:0] fetch_count;
`endif

  if_fetch_stage dut (
    .clk(clk), .rst(rst), .freeze(freeze),
    .branch_taken(branch_taken), .branch_addr(branch_addr),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_ack(imem_ack),
    .instruction(instruction), .pc_out(pc_out), .valid(valid),
`ifdef IF_FETCH_COUNT_EN
    .fetch_count(fetch_count),
`endif
    .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  int passes = 0;
  int total  = 0;

  // Reference model: the address the memory should be asked for next, whether
  // the in-flight request belongs to a squashed path, and a one-deep parked word.
  logic [31:0] m_next_addr;
  bit          m_squashed;
  logic [31:0] m_redirect;
  logic [31:0] parked_q[$];   // {instr, pc} pairs; at most one entry
  logic [31:0] m_instr, m_pc;
  bit          m_valid;
  logic [31:0] m_count;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'hBEEF, ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_next_addr = 32'd0;
    m_squashed  = 1'b0;
    m_redirect  = 32'd0;
    parked_q.delete();
    m_instr = 32'd0;
    m_pc    = 32'd0;
    m_valid = 1'b0;
    m_count = 32'd0;
  endtask

  function automatic bit model_req();
    return !rst && parked_q.size() == 0;
  endfunction

  task automatic deliver(input logic [31:0] instr, input logic [31:0] pc);
    m_instr = instr;
    m_pc    = pc;
    m_valid = 1'b1;
    m_count = m_count + 32'd1;
  endtask

  task automatic model_edge();
    logic [31:0] fetched_pc;
    fetched_pc = m_next_addr + 32'd4;
    if (rst) begin
      model_reset();
    end else if (parked_q.size() != 0) begin
      if (branch_taken) begin
        parked_q.delete();
        m_valid = 1'b0;
        m_next_addr = branch_addr;
      end else if (!freeze) begin
        deliver(parked_q[0], parked_q[1]);
        parked_q.delete();
        m_next_addr = fetched_pc;
      end
    end else if (m_squashed) begin
      m_valid = 1'b0;
      if (branch_taken) m_redirect = branch_addr;
      if (imem_ack) begin
        m_squashed  = 1'b0;
        m_next_addr = m_redirect;
      end
    end else if (branch_taken) begin
      m_valid = 1'b0;
      if (imem_ack) m_next_addr = branch_addr;
      else begin
        m_squashed = 1'b1;
        m_redirect = branch_addr;
      end
    end else if (imem_ack) begin
      if (freeze) begin
        parked_q.push_back(imem_rdata);
        parked_q.push_back(fetched_pc);
      end else begin
        deliver(imem_rdata, fetched_pc);
        m_next_addr = fetched_pc;
      end
    end else if (!freeze) begin
      m_valid = 1'b0;
    end
  endtask

  // One clock: drive inputs at negedge, check request, then edge, then check IF/ID.
  task automatic step(input bit r, input bit f, input bit b, input logic [31:0] ba,
                      input int ack_pct);
    bit exp_req;
    @(negedge clk);
    rst = r;
    freeze = f;
    branch_taken = b;
    branch_addr = ba;
    imem_ack = 1'b0;
    #1;
    exp_req = model_req();
    check("imem_req", {31'd0, imem_req}, {31'd0, exp_req});
    if (exp_req) check("imem_addr", imem_addr, m_next_addr);
    if ((exp_req || r) && ($urandom_range(99) < ack_pct)) begin
      imem_ack   = 1'b1;
      imem_rdata = mem_word(imem_addr);
    end else begin
      imem_rdata = $urandom;
    end
    @(posedge clk);
    model_edge();
    #1;
    check("valid", {31'd0, valid}, {31'd0, m_valid});
    check("instruction", instruction, m_instr);
    check("pc_out", pc_out, m_pc);
`ifdef IF_FETCH_COUNT_EN
    check("fetch_count", fetch_count, m_count);
`endif
  endtask

  initial begin
    model_reset();
    // Reset and zero-wait streaming
    step(1, 0, 0, 0, 100);
    step(1, 0, 0, 0, 0);
    check("reset_pc_out", pc_out, 32'd0);
    check("reset_valid", {31'd0, valid}, 32'd0);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 100);
    check("stream_pc_out", pc_out, 32'd20);

    // Two-cycle ack latency
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 100);
    check("latency_pc_out", pc_out, 32'd4);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 100);

    // Freeze while a word is acked, then release
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 100);
    step(0, 0, 0, 0, 100);
    step(0, 1, 0, 0, 100);
    check("frozen_pc_out", pc_out, 32'd8);
    step(0, 1, 0, 0, 100);
    step(0, 0, 0, 0, 100);
    check("released_pc_out", pc_out, 32'd12);
    step(0, 0, 0, 0, 100);

    // Redirect while a request is pending
    step(0, 0, 1, 32'h20, 100);
    step(0, 0, 1, 32'h100, 0);
    step(0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 100);
    step(0, 0, 0, 0, 100);
    check("redirect_pc_out", pc_out, 32'h104);
    // Newer redirect on the ack cycle of a squashed request
    step(0, 0, 1, 32'h300, 0);
    step(0, 0, 1, 32'h400, 100);
    step(0, 0, 0, 0, 100);
    check("latest_redirect_pc", pc_out, 32'h404);

    // Branch and freeze together while holding a word
    step(0, 1, 0, 0, 100);
    step(0, 1, 1, 32'h200, 100);
    check("hold_flush_valid", {31'd0, valid}, 32'd0);
    step(0, 0, 0, 0, 100);

    // Address wrap, then reset in the middle of a request
    step(0, 0, 1, 32'hFFFF_FFFC, 100);
    step(0, 0, 0, 0, 100);
    check("wrap_pc_out", pc_out, 32'd0);
    step(0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 100);
    check("midreq_reset_pc", pc_out, 32'd0);
    step(0, 0, 0, 0, 100);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(99) < 2, $urandom_range(99) < 30, $urandom_range(99) < 15,
           {$urandom, 2'b00} , 60);
    end

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule

// File: doc/if_fetch_stage.md
IF_FETCH_STAGE -- requirements
Module: if_fetch_stage

Interface
REQ-001 SHALL provide port: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL provide port: rst  input  1  synchronous, active-high reset.
REQ-003 SHALL provide port: freeze  input  1  hazard stall from decode; hold IF/ID outputs.
REQ-004 SHALL provide port: branch_taken  input  1  redirect request from execute.
REQ-005 SHALL provide port: branch_addr  input  32  redirect target; word-aligned.
REQ-006 SHALL provide port: imem_req  output  1  instruction-memory request valid.
REQ-007 SHALL provide port: imem_addr  output  32  instruction-memory word address, byte units.
REQ-008 SHALL provide port: imem_rdata  input  32  instruction word; valid when imem_ack=1.
REQ-009 SHALL provide port: imem_ack  input  1  request completion, same or later cycle as imem_req.
REQ-010 SHALL provide port: instruction  output  32  IF/ID instruction to decode.
REQ-011 SHALL provide port: pc_out  output  32  fetched address + 4.
REQ-012 SHALL provide port: valid  output  1  instruction/pc_out hold a live instruction.

Function
REQ-013 SHALL hold registers req_addr[31:0], target[31:0], buf_instr[31:0], buf_pc[31:0], state in {FETCH, DROP, HOLD}.
REQ-014 SHALL drive imem_req=1, imem_addr=req_addr in FETCH and DROP; imem_req=0 in HOLD and whenever rst=1.
REQ-015 SHALL keep imem_addr stable from request assertion until ack cycle (no abort).
REQ-016 FETCH, ack, no branch, no freeze: instruction<=imem_rdata, pc_out<=req_addr+4, valid<=1, req_addr<=req_addr+4; stay FETCH (1 instr/cycle with zero-wait memory).
REQ-017 FETCH, ack, no branch, freeze: buf_instr<=imem_rdata, buf_pc<=req_addr+4; outputs unchanged; go HOLD.
REQ-018 FETCH, no ack, no branch: if freeze=0 valid<=0 (bubble), else outputs unchanged; stay FETCH.
REQ-019 FETCH, ack, branch_taken: discard imem_rdata, req_addr<=branch_addr, valid<=0; stay FETCH.
REQ-020 FETCH, no ack, branch_taken: target<=branch_addr, valid<=0; go DROP.
REQ-021 DROP: on ack discard data, req_addr<=target, go FETCH; branch_taken in DROP overwrites target (latest wins), including ack cycle.
REQ-022 DROP: valid<=0 every cycle irrespective of freeze.
REQ-023 HOLD, freeze=0, no branch: instruction<=buf_instr, pc_out<=buf_pc, valid<=1, req_addr<=req_addr+4; go FETCH.
REQ-024 HOLD, freeze=1, no branch: all outputs and buffer unchanged.
REQ-025 HOLD, branch_taken: discard buffer, req_addr<=branch_addr, valid<=0; go FETCH.
REQ-026 branch_taken SHALL force valid<=0 on next edge regardless of freeze or state (flush beats stall).
REQ-027 req_addr+4 SHALL wrap modulo 2^32 (0xFFFFFFFC -> 0x00000000).
REQ-028 With freeze=1 and no branch, instruction/pc_out/valid SHALL not change.

Reset
REQ-029 On rst=1 at clock edge: req_addr=0, target=0, buf_instr=0, buf_pc=0, state=FETCH, instruction=0, pc_out=0, valid=0.
REQ-030 rst SHALL override every other input, including mid-request; an ack arriving while rst=1 SHALL be ignored.
REQ-031 First request after reset release SHALL be imem_addr=0x00000000 in the first cycle with rst=0.

Configuration
REQ-032 Macro IF_FETCH_COUNT_EN defined: extra output fetch_count[31:0], incremented by 1 on each edge where valid transitions into a new live instruction (REQ-016, REQ-023), reset 0, wraps at 2^32.
REQ-033 Macro IF_FETCH_COUNT_EN undefined: fetch_count port and counter absent; all other behaviour identical.

Verification
REQ-034 Zero-wait memory (ack=imem_req), no stall: after reset imem_addr=0,4,8,12 on consecutive cycles; pc_out=4,8,12 with valid=1 from second cycle.
REQ-035 Two-cycle ack latency: imem_addr=0 held 2 cycles, valid=0 on first edge, valid=1 pc_out=4 after ack.
REQ-036 freeze=1 during ack of addr 8: outputs stay pc_out=8; release freeze -> pc_out=12 with buffered word, next imem_addr=16.
REQ-037 branch_taken addr 0x100 while request to 0x20 pending: imem_addr stays 0x20 until ack, data discarded, next imem_addr=0x100, valid=0 throughout.
REQ-038 branch_taken and freeze same cycle in HOLD: valid=0 next cycle, buffer dropped, imem_addr=branch_addr.
REQ-039 req_addr 0xFFFFFFFC acked: pc_out=0x00000000, next imem_addr=0x00000000; rst asserted mid-request -> imem_req=0, all outputs 0, restart at 0.
